// File: rtl/data_loader_gen.sv
// data_loader_gen: buffers APF bridge writes in a small FIFO and serialises
// each 32-bit bridge word into 1, 2 or 4 memory-word writes in clk_74a.
module data_loader_gen #(
  parameter logic [3:0]  ADDRESS_MASK_UPPER_4      = 4'h0,
  parameter int unsigned ADDRESS_SIZE              = 14,
  parameter int unsigned OUTPUT_WORD_SIZE          = 2,
  parameter int unsigned WRITE_MEM_CLOCK_DELAY     = 0,
  parameter int unsigned WRITE_MEM_EN_CYCLE_LENGTH = 1,
  parameter int unsigned FIFO_DEPTH                = 4
) (
  input  logic                          clk_74a,
  input  logic                          reset_n,
  input  logic                          bridge_wr,
  input  logic                          bridge_endian_little,
  input  logic [31:0]                   bridge_addr,
  input  logic [31:0]                   bridge_wr_data,
  output logic                          write_en,
  output logic [ADDRESS_SIZE-1:0]       write_addr,
  output logic [8*OUTPUT_WORD_SIZE-1:0] write_data,
  output logic                          busy,
  output logic                          overflow
);

  localparam int unsigned WORD_W     = 8 * OUTPUT_WORD_SIZE;
  localparam int unsigned NUM_WORDS  = 4 / OUTPUT_WORD_SIZE;
  localparam int unsigned WORD_SHIFT = $clog2(OUTPUT_WORD_SIZE);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W1     = PTR_W + 1;
  localparam int unsigned CNT_W      = 4;

  localparam logic [CNT_W-1:0] SETUP_LAST =
    (WRITE_MEM_CLOCK_DELAY == 0) ? '0 : CNT_W'(WRITE_MEM_CLOCK_DELAY - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(WRITE_MEM_EN_CYCLE_LENGTH - 1);
  localparam logic [1:0]       LAST_WORD   = 2'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  // A word either waits out the setup delay or strobes immediately
  localparam state_t WORD_START = (WRITE_MEM_CLOCK_DELAY == 0) ? STROBE : SETUP;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [27:0]       fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1+1:0] wr_ptr;
  logic [PTR_W-1+1:0] rd_ptr;

  logic        empty_c;
  logic        full_c;
  logic        accept_c;
  logic        push_c;
  logic        pop_c;
  logic        load_first_c;
  logic        load_next_c;
  logic        setup_done_c;
  logic        strobe_done_c;
  logic        last_word_c;
  logic [31:0] norm_data_c;
  logic [27:0] head_addr_c;
  logic [31:0] head_data_c;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        word_idx;
  logic [27:0]       cur_addr;
  logic [31:0]       cur_data;
  logic [ADDRESS_SIZE-1:0] word_addr;
  logic [WORD_W-1:0]       word_data;

  // Memory word address of word k of a bridge word at byte address base
  function automatic logic [ADDRESS_SIZE-1:0] calc_addr(input logic [27:0] base,
                                                         input logic [1:0]  k);
    logic [27:0] sum;
    sum = base + (28'(k) << WORD_SHIFT);
    return ADDRESS_SIZE'(sum >> WORD_SHIFT);
  endfunction

  // Bytes of word k, lowest-addressed byte in [7:0]
  function automatic logic [WORD_W-1:0] calc_data(input logic [31:0] data,
                                                   input logic [1:0]  k);
    logic [31:0] sh;
    sh = data >> ({3'b000, k} << (WORD_SHIFT + 3));
    return WORD_W'(sh);
  endfunction

  assign empty_c  = (wr_ptr == rd_ptr);
  assign full_c   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign accept_c = bridge_wr && (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);
  assign push_c   = accept_c && (!full_c || pop_c);

  assign norm_data_c = bridge_endian_little ? bridge_wr_data :
                       {bridge_wr_data[7:0], bridge_wr_data[15:8],
                        bridge_wr_data[23:16], bridge_wr_data[31:24]};

  assign head_addr_c = fifo_addr[rd_ptr[PTR_W-1:0]];
  assign head_data_c = fifo_data[rd_ptr[PTR_W-1:0]];

  assign setup_done_c  = (state == SETUP)  && (cnt == SETUP_LAST);
  assign strobe_done_c = (state == STROBE) && (cnt == STROBE_LAST);
  assign last_word_c   = (word_idx == LAST_WORD);

  // Serialiser state register
  always_ff @(posedge clk_74a) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Serialiser next state; the last strobe chains straight into the next entry
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (!empty_c) state_next = WORD_START;
      SETUP:  if (setup_done_c) state_next = STROBE;
      STROBE: begin
        if (strobe_done_c) begin
          if (!last_word_c || !empty_c) state_next = WORD_START;
          else                          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Serialiser control outputs: FIFO pop and word loads
  always_comb begin
    pop_c        = 1'b0;
    load_first_c = 1'b0;
    load_next_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty_c) begin
          pop_c        = 1'b1;
          load_first_c = 1'b1;
        end
      end
      STROBE: begin
        if (strobe_done_c) begin
          if (!last_word_c) begin
            load_next_c = 1'b1;
          end else if (!empty_c) begin
            pop_c        = 1'b1;
            load_first_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Phase counter, restarted whenever a word loads or setup completes
  always_ff @(posedge clk_74a) begin
    if (!reset_n)                                    cnt <= '0;
    else if (load_first_c || load_next_c || setup_done_c) cnt <= '0;
    else if (state != IDLE)                          cnt <= cnt + CNT_W'(1);
  end

  // Current bridge entry and the word being presented
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      cur_addr  <= '0;
      cur_data  <= '0;
      word_idx  <= '0;
      word_addr <= '0;
      word_data <= '0;
    end else if (load_first_c) begin
      cur_addr  <= head_addr_c;
      cur_data  <= head_data_c;
      word_idx  <= '0;
      word_addr <= calc_addr(head_addr_c, 2'd0);
      word_data <= calc_data(head_data_c, 2'd0);
    end else if (load_next_c) begin
      word_idx  <= word_idx + 2'd1;
      word_addr <= calc_addr(cur_addr, word_idx + 2'd1);
      word_data <= calc_data(cur_data, word_idx + 2'd1);
    end
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W1'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W1'(1);
      if (accept_c && full_c && !pop_c) overflow <= 1'b1;
    end
  end

  // FIFO storage; entries hold normalised data
  always_ff @(posedge clk_74a) begin
    if (push_c) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= bridge_addr[27:0];
      fifo_data[wr_ptr[PTR_W-1:0]] <= norm_data_c;
    end
  end

  // Registered memory-side outputs
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      busy       <= 1'b0;
    end else begin
      write_en   <= (state == STROBE);
      write_addr <= word_addr;
      write_data <= word_data;
      busy       <= !empty_c || (state != IDLE);
    end
  end

endmodule

// File: tb/tb_data_loader_gen.sv
// Directed bench for data_loader_gen across several parameter sets.
module tb_data_loader_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bridge_wr;
  logic        le;
  logic [31:0] baddr;
  logic [31:0] bdata;

  logic a_en, a_busy, a_ovf;  logic [13:0] a_addr; logic [15:0] a_data;
  logic b_en, b_busy, b_ovf;  logic [13:0] b_addr; logic [15:0] b_data;
  logic c_en, c_busy, c_ovf;  logic [13:0] c_addr; logic [7:0]  c_data;
  logic d_en, d_busy, d_ovf;  logic [13:0] d_addr; logic [31:0] d_data;
  logic e_en, e_busy, e_ovf;  logic [13:0] e_addr; logic [15:0] e_data;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  int          b_cyc_q [$];
  logic [13:0] b_addr_q [$];
  logic [15:0] b_data_q [$];
  int          e_hits = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_loader_gen u_a (
    .clk_74a(clk), .reset_n(reset_n), .bridge_wr(bridge_wr), .bridge_endian_little(le),
    .bridge_addr(baddr), .bridge_wr_data(bdata), .write_en(a_en), .write_addr(a_addr),
    .write_data(a_data), .busy(a_busy), .overflow(a_ovf));

  data_loader_gen #(.WRITE_MEM_CLOCK_DELAY(4), .WRITE_MEM_EN_CYCLE_LENGTH(1), .FIFO_DEPTH(4)) u_b (
    .clk_74a(clk), .reset_n(reset_n), .bridge_wr(bridge_wr), .bridge_endian_little(le),
    .bridge_addr(baddr), .bridge_wr_data(bdata), .write_en(b_en), .write_addr(b_addr),
    .write_data(b_data), .busy(b_busy), .overflow(b_ovf));

  data_loader_gen #(.OUTPUT_WORD_SIZE(1)) u_c (
    .clk_74a(clk), .reset_n(reset_n), .bridge_wr(bridge_wr), .bridge_endian_little(le),
    .bridge_addr(baddr), .bridge_wr_data(bdata), .write_en(c_en), .write_addr(c_addr),
    .write_data(c_data), .busy(c_busy), .overflow(c_ovf));

  data_loader_gen #(.OUTPUT_WORD_SIZE(4)) u_d (
    .clk_74a(clk), .reset_n(reset_n), .bridge_wr(bridge_wr), .bridge_endian_little(le),
    .bridge_addr(baddr), .bridge_wr_data(bdata), .write_en(d_en), .write_addr(d_addr),
    .write_data(d_data), .busy(d_busy), .overflow(d_ovf));

  data_loader_gen #(.WRITE_MEM_EN_CYCLE_LENGTH(3)) u_e (
    .clk_74a(clk), .reset_n(reset_n), .bridge_wr(bridge_wr), .bridge_endian_little(le),
    .bridge_addr(baddr), .bridge_wr_data(bdata), .write_en(e_en), .write_addr(e_addr),
    .write_data(e_data), .busy(e_busy), .overflow(e_ovf));

  // Strobe logs
  always @(negedge clk) begin
    if (b_en) begin
      b_cyc_q.push_back(cyc);
      b_addr_q.push_back(b_addr);
      b_data_q.push_back(b_data);
    end
    if (e_en) e_hits <= e_hits + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bridge write; returns at the negedge following its sample edge
  task automatic bw(input logic [31:0] a, input logic [31:0] d, input logic little);
    baddr = a; bdata = d; le = little; bridge_wr = 1'b1;
    @(negedge clk);
    bridge_wr = 1'b0; baddr = '0; bdata = '0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    int t;
    int t0;
    int b_base;
    int e_base;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;

    reset_n = 1'b0; bridge_wr = 1'b0; le = 1'b0; baddr = '0; bdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_en",   a_en, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_data", a_data, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ovf",  a_ovf, 0);
    chk("rst_dd",   d_data, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Big endian, two 16-bit words
    bw(32'h0000_0000, 32'h1122_3344, 1'b0); t = cyc;
    wait_cyc(t + 1);
    chk("be_en_early", a_en, 0);
    chk("be_busy1", a_busy, 1);
    wait_cyc(t + 2);
    chk("be_en0", a_en, 1);
    chk("be_addr0", a_addr, 0);
    chk("be_data0", a_data, 16'h2211);
    chk("ows4_en", d_en, 1);
    chk("ows4_data", d_data, 32'h4433_2211);
    chk("ows1_data0", c_data, 8'h11);
    wait_cyc(t + 3);
    chk("be_en1", a_en, 1);
    chk("be_addr1", a_addr, 1);
    chk("be_data1", a_data, 16'h4433);
    chk("be_busy3", a_busy, 1);
    chk("ows4_en_off", d_en, 0);
    wait_cyc(t + 4);
    chk("be_en_off", a_en, 0);
    chk("be_busy_off", a_busy, 0);
    chk("be_addr_hold", a_addr, 1);
    wait_cyc(t + 40);

    // Little endian
    bw(32'h0000_0000, 32'h1122_3344, 1'b1); t = cyc;
    wait_cyc(t + 2);
    chk("le_addr0", a_addr, 0);
    chk("le_data0", a_data, 16'h3344);
    wait_cyc(t + 3);
    chk("le_addr1", a_addr, 1);
    chk("le_data1", a_data, 16'h1122);
    wait_cyc(t + 4);
    chk("le_en_off", a_en, 0);
    wait_cyc(t + 40);

    // Out-of-window write is ignored
    bw(32'h1000_0004, 32'hDEAD_BEEF, 1'b1); t = cyc;
    for (int i = 1; i <= 6; i++) begin
      wait_cyc(t + i);
      chk("win_en", a_en, 0);
      chk("win_busy", a_busy, 0);
      chk("win_busy_b", b_busy, 0);
      chk("win_ovf", a_ovf, 0);
    end
    wait_cyc(t + 20);

    // Burst of six into a depth-4 FIFO with setup delay 4
    b_base = b_cyc_q.size();
    t0 = 0;
    for (int i = 0; i < 6; i++) begin
      baddr = 32'(4 * i);
      bdata = 32'h0302_0100 + 32'(i) * 32'h0404_0404;
      le = 1'b1; bridge_wr = 1'b1;
      @(negedge clk);
      if (i == 0) t0 = cyc;
    end
    bridge_wr = 1'b0; baddr = '0; bdata = '0;
    wait_cyc(t0 + 70);
    chk("burst_count", 64'(b_cyc_q.size() - b_base), 10);
    for (int j = 0; j < 10; j++) begin
      if (b_base + j < b_cyc_q.size()) begin
        chk("burst_addr", b_addr_q[b_base + j], 14'(j));
        chk("burst_data", b_data_q[b_base + j], {8'(2 * j + 1), 8'(2 * j)});
        chk("burst_cyc", 64'(b_cyc_q[b_base + j]), 64'(t0 + 6 + 5 * j));
      end
    end
    chk("burst_ovf_b", b_ovf, 1);
    chk("burst_ovf_a", a_ovf, 0);
    chk("burst_busy_b", b_busy, 0);

    // Byte-wide serialisation
    bw(32'h0000_0008, 32'hAABB_CCDD, 1'b0); t = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_cyc(t + 2 + k);
      chk("ows1_en", c_en, 1);
      chk("ows1_addr", c_addr, 14'(8 + k));
      chk("ows1_data", c_data, exp_b[k]);
    end
    wait_cyc(t + 40);

    // Single 32-bit word
    bw(32'h0000_0010, 32'hAABB_CCDD, 1'b0); t = cyc;
    wait_cyc(t + 2);
    chk("ows4_en2", d_en, 1);
    chk("ows4_addr2", d_addr, 4);
    chk("ows4_data2", d_data, 32'hDDCC_BBAA);
    wait_cyc(t + 3);
    chk("ows4_off2", d_en, 0);
    wait_cyc(t + 40);

    // Reset in the middle of a 3-cycle strobe
    bw(32'h0000_0020, 32'h1234_5678, 1'b1); t = cyc;
    wait_cyc(t + 2);
    chk("rs_en_pre", e_en, 1);
    chk("rs_addr_pre", e_addr, 14'h10);
    chk("rs_data_pre", e_data, 16'h5678);
    chk("rs_busy_pre", e_busy, 1);
    reset_n = 1'b0;
    wait_cyc(t + 3);
    chk("rs_en", e_en, 0);
    chk("rs_busy", e_busy, 0);
    chk("rs_addr", e_addr, 0);
    chk("rs_ovf_b", b_ovf, 0);
    wait_cyc(t + 4);
    reset_n = 1'b1;
    e_base = e_hits;
    wait_cyc(t + 20);
    chk("rs_leftover", 64'(e_hits - e_base), 0);

    bw(32'h0000_0040, 32'h5566_7788, 1'b1); t = cyc;
    wait_cyc(t + 2);
    chk("rs2_en0", e_en, 1);
    chk("rs2_addr0", e_addr, 14'h20);
    chk("rs2_data0", e_data, 16'h7788);
    wait_cyc(t + 4);
    chk("rs2_en0_end", e_en, 1);
    chk("rs2_addr0_end", e_addr, 14'h20);
    wait_cyc(t + 5);
    chk("rs2_addr1", e_addr, 14'h21);
    chk("rs2_data1", e_data, 16'h5566);
    wait_cyc(t + 8);
    chk("rs2_en_off", e_en, 0);
    chk("rs2_busy_off", e_busy, 0);
    wait_cyc(t + 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
